// File: rtl/cic_decimator_if.sv
// Sample-stream handshake bundle for cic_decimator: valid-qualified input
// and valid/ready output channel.
`timescale 1ns/1ps

interface cic_decimator_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/cic_decimator.sv
// CIC decimator: STAGES integrators at input rate, pipelined combs at output
// rate, runtime ratio/gain. Define CIC_SATURATE_EN to clamp instead of wrap.
`timescale 1ns/1ps

module cic_decimator #(
    parameter int IN_W    = 12,
    parameter int OUT_W   = 12,
    parameter int STAGES  = 5,
    parameter int ACC_W   = 64,
    parameter int RATIO_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [RATIO_W-1:0] ratio,
    input  logic [7:0]         gain,
    cic_decimator_if.slave     bus,
    output logic               dec_clk,
    output logic               overrun
);
    localparam int HEAD = ACC_W - OUT_W;

    logic [RATIO_W-1:0]      r_lat;
    logic [RATIO_W-1:0]      r_next;
    logic [RATIO_W-1:0]      cnt;
    logic                    last_in;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] integ [STAGES];
    logic signed [ACC_W-1:0] capture;
    logic                    strobe;
    logic signed [ACC_W-1:0] comb [STAGES];
    logic signed [ACC_W-1:0] dly  [STAGES];
    logic [STAGES-1:0]       cvld;
    logic [31:0]             shift;
    logic [OUT_W-1:0]        result;
    logic                    load;

    always_comb begin
        r_next  = (ratio < RATIO_W'(2)) ? RATIO_W'(2) : ratio;
        last_in = bus.in_valid && (cnt == r_lat - RATIO_W'(1));
        in_ext  = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        load    = cvld[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (bus.in_valid) begin
            integ[0] <= integ[0] + in_ext;
            for (int unsigned k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Capture takes the pre-update last integrator; the new ratio applies from the next frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            r_lat   <= r_next;
            capture <= '0;
            strobe  <= 1'b0;
            dec_clk <= 1'b0;
        end else begin
            strobe <= last_in;
            if (last_in) capture <= integ[STAGES-1];
            if (bus.in_valid) begin
                if (last_in) begin
                    cnt   <= '0;
                    r_lat <= r_next;
                end else begin
                    cnt <= cnt + RATIO_W'(1);
                end
            end
            if (last_in) dec_clk <= 1'b1;
            else if (cnt == (r_lat >> 1)) dec_clk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cvld <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
        end else begin
            cvld[0] <= strobe;
            if (strobe) begin
                comb[0] <= capture - dly[0];
                dly[0]  <= capture;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                cvld[k] <= cvld[k-1];
                if (cvld[k-1]) begin
                    comb[k] <= comb[k-1] - dly[k];
                    dly[k]  <= comb[k-1];
                end
            end
        end
    end

`ifdef CIC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [ACC_W-1:0] scaled;

    always_comb begin
        shift  = (32'(gain) >= 32'(HEAD)) ? '0 : 32'(HEAD) - 32'(gain);
        scaled = comb[STAGES-1] >>> shift;
        if (scaled > SAT_MAX)      result = SAT_MAX[OUT_W-1:0];
        else if (scaled < SAT_MIN) result = SAT_MIN[OUT_W-1:0];
        else                       result = scaled[OUT_W-1:0];
    end
`else
    always_comb begin
        shift  = (32'(gain) >= 32'(HEAD)) ? '0 : 32'(HEAD) - 32'(gain);
        result = OUT_W'(comb[STAGES-1] >>> shift);
    end
`endif

    // A load wins over acceptance; it only flags overrun when the old result was not taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            overrun       <= 1'b0;
        end else if (load) begin
            bus.out_data  <= result;
            bus.out_valid <= 1'b1;
            if (bus.out_valid && !bus.out_ready) overrun <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: captures are modelled as an N-th order
// binomial difference of frame-end integrator values, checked when loaded.
`timescale 1ns/1ps

module tb_cic_decimator;
    localparam int IN_W = 12, OUT_W = 12, STAGES = 5, ACC_W = 64, RATIO_W = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [RATIO_W-1:0] ratio = 16;
    logic [7:0]         gain = 40;
    logic               dec_clk, overrun;

    cic_decimator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

    cic_decimator #(.IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .ACC_W(ACC_W), .RATIO_W(RATIO_W)) dut (
        .clk(clk), .rstn(rstn), .ratio(ratio), .gain(gain),
        .bus(bus.slave), .dec_clk(dec_clk), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    typedef struct { longint raw; longint due; } pend_t;
    pend_t   q[$];
    longint  m_int [STAGES];
    longint  m_hist [STAGES+1];
    int unsigned m_cnt, m_r, n_loads, n_in;
    bit      m_valid, m_ovr, m_dclk;
    longint  m_data, cyc = 0;
    longint  dclk_rise[$], ov_rise[$];
    int      dut_caps[$];

    function automatic int unsigned clamp_r(logic [RATIO_W-1:0] r);
        return (r < 2) ? 2 : int'(r);
    endfunction

    function automatic longint comb_ref();
        longint y = 0, c = 1;
        for (int j = 0; j <= STAGES; j++) begin
            y += (j % 2 == 1) ? -(c * m_hist[j]) : c * m_hist[j];
            c = c * (STAGES - j) / (j + 1);
        end
        return y;
    endfunction

    function automatic longint scale_ref(longint y, logic [7:0] g);
        int sh;
        logic signed [63:0] s;
        logic signed [11:0] w;
        sh = (int'(g) >= ACC_W - OUT_W) ? 0 : ACC_W - OUT_W - int'(g);
        s = y >>> sh;
        w = s[11:0];
`ifdef CIC_SATURATE_EN
        if (s > 2047) return 2047;
        if (s < -2048) return -2048;
        return s;
`else
        return longint'(w);
`endif
    endfunction

    task automatic model_edge();
        bit cap;
        pend_t p;
        cyc++;
        if (!rstn) begin
            q.delete();
            for (int k = 0; k < STAGES; k++) m_int[k] = 0;
            for (int k = 0; k <= STAGES; k++) m_hist[k] = 0;
            m_cnt = 0; m_r = clamp_r(ratio);
            m_valid = 0; m_ovr = 0; m_dclk = 0; m_data = 0;
            n_loads = 0;
            return;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            p = q.pop_front();
            if (m_valid && !bus.out_ready) m_ovr = 1;
            m_valid = 1;
            m_data = scale_ref(p.raw, gain);
            n_loads++;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
        cap = bus.in_valid && (m_cnt == m_r - 1);
        if (cap) m_dclk = 1;
        else if (m_cnt == (m_r >> 1)) m_dclk = 0;
        if (bus.in_valid) begin
            if (cap) begin
                for (int k = STAGES; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = m_int[STAGES-1];
                q.push_back('{raw: comb_ref(), due: cyc + STAGES + 1});
                m_cnt = 0;
                m_r = clamp_r(ratio);
            end else begin
                m_cnt++;
            end
            for (int k = STAGES - 1; k > 0; k--) m_int[k] += m_int[k-1];
            m_int[0] += longint'($signed(bus.in_data));
        end
    endtask

    task automatic step(input bit v, input logic [IN_W-1:0] d, input bit rdy);
        logic pd, pv;
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = rdy;
        if (v && rstn) n_in++;
        pd = dec_clk;
        pv = bus.out_valid;
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", bus.out_valid, m_valid);
        check("out_data", $signed(bus.out_data), m_data);
        check("overrun", overrun, m_ovr);
        check("dec_clk", dec_clk, m_dclk);
        if (dec_clk === 1'b1 && pd !== 1'b1) begin
            dclk_rise.push_back(cyc);
            dut_caps.push_back(n_in);
        end
        if (bus.out_valid === 1'b1 && pv !== 1'b1) ov_rise.push_back(cyc);
    endtask

    task automatic do_reset(input int unsigned n);
        rstn = 1'b0;
        for (int i = 0; i < n; i++) step(0, '0, 1);
        rstn = 1'b1;
        n_in = 0;
        dclk_rise.delete(); ov_rise.delete(); dut_caps.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        longint second;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
        n_in = 0;

        // DC gain: R^N = 2^20, shifted right by 12
        ratio = 16; gain = 40;
        do_reset(2);
        check("rst_data", $signed(bus.out_data), 0);
        check("rst_valid", bus.out_valid, 0);
        for (int k = 0; k < 128; k++) step(1, 12'd1, 1);
        for (int k = 0; k < 10; k++) step(0, '0, 1);
        check("dc_256", $signed(bus.out_data), 256);

        // Full-scale input with no shift
        gain = 52;
        do_reset(1);
        for (int k = 0; k < 128; k++) step(1, 12'd2047, 1);
        for (int k = 0; k < 10; k++) step(0, '0, 1);
`ifdef CIC_SATURATE_EN
        check("fullscale", $signed(bus.out_data), 2047);
`else
        check("fullscale", $signed(bus.out_data), 0);
`endif

        // Ratio change mid-frame takes effect on the next frame
        ratio = 16; gain = 40;
        do_reset(1);
        for (i = 0; i < 300 && n_in < 40; i++) begin
            if (n_in == 5) ratio = 8;
            step($urandom_range(0, 1), 12'($urandom_range(0, 4095)), 1);
        end
        for (int k = 0; k < 10; k++) step(0, '0, 1);
        if (dut_caps.size() >= 2) begin
            check("frame_first", dut_caps[0], 16);
            check("frame_next", dut_caps[1] - dut_caps[0], 8);
        end else begin
            check("frame_count", dut_caps.size(), 2);
        end

        // Half-rate input, R=4: output and dec_clk every 8 clocks
        ratio = 4;
        do_reset(1);
        for (int k = 0; k < 80; k++) step((k % 2) == 0, 12'($urandom_range(0, 4095)), 1);
        check("dclk_rises", dclk_rise.size() >= 5, 1);
        check("ov_rises", ov_rise.size() >= 5, 1);
        for (int k = 1; k < dclk_rise.size(); k++) check("dclk_period", dclk_rise[k] - dclk_rise[k-1], 8);
        for (int k = 1; k < ov_rise.size(); k++) check("ov_period", ov_rise[k] - ov_rise[k-1], 8);

        // Two results without acceptance
        ratio = 4;
        do_reset(1);
        for (i = 0; i < 100 && n_loads < 2; i++) step(1, 12'($urandom_range(0, 4095)), 0);
        check("ovr_loads", n_loads, 2);
        second = m_data;
        check("ovr_set", overrun, 1);
        check("ovr_data", $signed(bus.out_data), second);
        step(0, '0, 1);
        check("ovr_clr_valid", bus.out_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Reset 10 inputs into the second frame
        ratio = 16;
        do_reset(1);
        for (int k = 0; k < 26; k++) step(1, 12'd2047, 0);
        rstn = 1'b0;
        step(0, '0, 1);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", $signed(bus.out_data), 0);
        check("mid_rst_dclk", dec_clk, 0);
        check("mid_rst_ovr", overrun, 0);
        rstn = 1'b1;
        for (i = 1; i <= 100; i++) begin
            step(i <= 16, 12'd2047, 1);
            if (bus.out_valid === 1'b1) break;
        end
        check("rst_latency", i, 16 + STAGES + 1);

        // Random soak: ratios incl. below-2, changing gain, valid and ready
        ratio = 0;
        do_reset(1);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) ratio = RATIO_W'($urandom_range(0, 7));
            gain = 8'($urandom_range(30, 60));
            step($urandom_range(0, 3) != 0, 12'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
